// File: rtl/dmem_ws.sv
// Parametrised single-port data memory with byte enables, programmable wait states and req/ready/done handshake.
// Optional power-up clear sweep is built when the DMEM_CLEAR_EN macro is defined.
module dmem_ws #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int DEPTH       = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [DATA_W-1:0]     wdata,
    output logic                  ready,
    output logic                  done,
    output logic [DATA_W-1:0]     rdata,
    output logic                  err
);

    localparam int NB     = DATA_W / 8;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      WS_L    = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_IDLE  = 2'd1,
        S_BUSY  = 2'd2
    } state_t;

    state_t              state_reg;
    logic [3:0]          cnt_reg;
    logic                we_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [NB-1:0]       be_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic                done_reg;
    logic                err_reg;
    logic [DATA_W-1:0]   rdata_reg;

    logic                in_range;
    logic                finish;
    logic                mem_we;
    logic [MEM_AW-1:0]   mem_waddr;
    logic [NB-1:0]       mem_wbe;
    logic [DATA_W-1:0]   mem_wdata;
    logic [MEM_AW-1:0]   rd_idx;
    logic [DATA_W-1:0]   rd_word;

`ifdef DMEM_CLEAR_EN
    localparam logic [MEM_AW-1:0] LAST_ADDR = MEM_AW'(DEPTH - 1);
    logic [MEM_AW-1:0]   clear_addr_reg;
`endif

    assign in_range = ({1'b0, addr_reg} < DEPTH_L);
    assign finish   = (state_reg == S_BUSY) && (cnt_reg == 4'd0);
    assign rd_idx   = addr_reg[MEM_AW-1:0];

    // Single write port shared between the access path and the clear sweep.
    always_comb begin
        mem_we    = finish && we_reg && in_range;
        mem_waddr = addr_reg[MEM_AW-1:0];
        mem_wbe   = be_reg;
        mem_wdata = wdata_reg;
`ifdef DMEM_CLEAR_EN
        if (state_reg == S_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clear_addr_reg;
            mem_wbe   = '1;
            mem_wdata = '0;
        end
`endif
    end

    // One 8-bit array per byte lane so each byte enable maps onto its own write strobe.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            logic [7:0] lane_mem [0:DEPTH-1];

            always_ff @(posedge clk) begin
                if (mem_we && mem_wbe[gi]) begin
                    lane_mem[mem_waddr] <= mem_wdata[gi*8 +: 8];
                end
            end

            assign rd_word[gi*8 +: 8] = lane_mem[rd_idx];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
`ifdef DMEM_CLEAR_EN
            state_reg      <= S_CLEAR;
            clear_addr_reg <= '0;
`else
            state_reg      <= S_IDLE;
`endif
            cnt_reg   <= 4'd0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            be_reg    <= '0;
            wdata_reg <= '0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
            rdata_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                S_CLEAR: begin
`ifdef DMEM_CLEAR_EN
                    if (clear_addr_reg == LAST_ADDR) begin
                        state_reg <= S_IDLE;
                    end else begin
                        clear_addr_reg <= clear_addr_reg + 1'b1;
                    end
`else
                    state_reg <= S_IDLE;
`endif
                end
                S_IDLE: begin
                    if (req) begin
                        we_reg    <= we;
                        addr_reg  <= addr;
                        be_reg    <= be;
                        wdata_reg <= wdata;
                        cnt_reg   <= WS_L;
                        state_reg <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (cnt_reg == 4'd0) begin
                        done_reg <= 1'b1;
                        err_reg  <= !in_range;
                        if (!we_reg) begin
                            rdata_reg <= in_range ? rd_word : '0;
                        end
                        state_reg <= S_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign ready = (state_reg == S_IDLE);
    assign done  = done_reg;
    assign err   = err_reg;
    assign rdata = rdata_reg;

endmodule
